// File: rtl/lru_press_player.sv
// lru_press_player: stores up to DEPTH button-press codes and replays them as
// timed presses on b1..b5, each press followed by an equal all-low gap.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   load_valid/slot   press-code offer (0-4 = b1-b5, 7 = rest, 5-6 illegal)
//   load_ready        offer can be taken this cycle
//   load_err          one-cycle pulse after an illegal code was offered
//   clr               empty the store (IDLE only)
//   start, abort      begin / stop replay
//   b1..b5            registered button drives, at most one high
//   busy              replay in progress (PRESS or GAP)
//   done              one-cycle pulse when a sequence pass completes
//   count             number of stored codes
//
// Build option: define LRU_PRESS_PLAYER_LOOP_EN to replay the sequence
// continuously (done pulses at every wrap) until abort or reset.

module lru_press_player #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [2:0] load_slot,
  output logic       load_ready,
  output logic       load_err,
  input  logic       clr,
  input  logic       start,
  input  logic       abort,
  output logic       b1,
  output logic       b2,
  output logic       b3,
  output logic       b4,
  output logic       b5,
  output logic       busy,
  output logic       done,
  output logic [3:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TMR_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state_q, state_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [PW-1:0] ptr_q, ptr_nx;
  logic [TW-1:0] tmr_q, tmr_nx;
  logic [4:0]    btn_q, btn_nx;
  logic          done_q, done_nx;
  logic          err_q, err_nx;
  logic          wr_en;
  logic          accept;
  logic          legal;
  logic          last_tick;
  logic          last_evt;
  logic [2:0]    mem [DEPTH];

  // Button one-hot for a stored code; rest (7) drives nothing.
  function automatic logic [4:0] decode(input logic [2:0] code);
    logic [4:0] m;
    m = 5'b00000;
    case (code)
      3'd0:    m = 5'b00001;
      3'd1:    m = 5'b00010;
      3'd2:    m = 5'b00100;
      3'd3:    m = 5'b01000;
      3'd4:    m = 5'b10000;
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

  // Ready is gated by rst so it reads low throughout reset.
  assign load_ready = rst && (state_q == IDLE) && (cnt_q < CW'(DEPTH)) && !clr;
  assign accept     = load_valid && load_ready;
  assign legal      = (load_slot != 3'd5) && (load_slot != 3'd6);
  assign last_tick  = (tmr_q == TMR_LAST);
  assign last_evt   = (CW'(ptr_q) == (cnt_q - CW'(1)));

  // Next-state, pointer, timer and registered-output logic.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    ptr_nx   = ptr_q;
    tmr_nx   = tmr_q;
    btn_nx   = btn_q;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        btn_nx = 5'b00000;
        tmr_nx = '0;
        ptr_nx = '0;
        if (clr) begin
          cnt_nx = '0;
        end else if (accept) begin
          // Any handshake, legal or not, suppresses a same-cycle start.
          if (legal) begin
            wr_en  = 1'b1;
            cnt_nx = cnt_q + CW'(1);
          end else begin
            err_nx = 1'b1;
          end
        end else if (start) begin
          if (cnt_q == '0) begin
            done_nx = 1'b1;
          end else begin
            state_nx = PRESS;
            btn_nx   = decode(mem[0]);
          end
        end
      end
      PRESS: begin
        if (abort) begin
          state_nx = IDLE;
          btn_nx   = 5'b00000;
          tmr_nx   = '0;
          ptr_nx   = '0;
        end else if (last_tick) begin
          state_nx = GAP;
          btn_nx   = 5'b00000;
          tmr_nx   = '0;
        end else begin
          tmr_nx = tmr_q + TW'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_nx = IDLE;
          btn_nx   = 5'b00000;
          tmr_nx   = '0;
          ptr_nx   = '0;
        end else if (last_tick) begin
          tmr_nx = '0;
          if (last_evt) begin
`ifdef LRU_PRESS_PLAYER_LOOP_EN
            done_nx  = 1'b1;
            ptr_nx   = '0;
            state_nx = PRESS;
            btn_nx   = decode(mem[0]);
`else
            done_nx  = 1'b1;
            ptr_nx   = '0;
            state_nx = IDLE;
            btn_nx   = 5'b00000;
`endif
          end else begin
            ptr_nx   = ptr_q + PW'(1);
            state_nx = PRESS;
            btn_nx   = decode(mem[ptr_q + PW'(1)]);
          end
        end else begin
          tmr_nx = tmr_q + TW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        btn_nx   = 5'b00000;
        tmr_nx   = '0;
        ptr_nx   = '0;
      end
    endcase
  end

  // State and output registers; async reset drops buttons immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      tmr_q   <= '0;
      btn_q   <= 5'b00000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      ptr_q   <= ptr_nx;
      tmr_q   <= tmr_nx;
      btn_q   <= btn_nx;
      done_q  <= done_nx;
      err_q   <= err_nx;
    end
  end

  // Event store; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[PW'(cnt_q)] <= load_slot;
    end
  end

  assign {b5, b4, b3, b2, b1} = btn_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign load_err = err_q;
  assign count    = 4'(cnt_q);

endmodule

// File: tb/tb_lru_press_player.sv
// Testbench for lru_press_player (DEPTH=8, TICK_DIV=4): table-driven load
// vectors plus scoreboarded replay traces built from a bench-side model of
// the stored sequence.

module tb_lru_press_player;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [2:0] load_slot;
  logic       load_ready;
  logic       load_err;
  logic       clr;
  logic       start;
  logic       abort;
  logic       b1, b2, b3, b4, b5;
  logic       busy;
  logic       done;
  logic [3:0] count;

  always #5 clk = ~clk;

  lru_press_player #(
    .DEPTH   (DEPTH),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_slot (load_slot),
    .load_ready(load_ready),
    .load_err  (load_err),
    .clr       (clr),
    .start     (start),
    .abort     (abort),
    .b1        (b1),
    .b2        (b2),
    .b3        (b3),
    .b4        (b4),
    .b5        (b5),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  typedef struct packed {
    logic [4:0] b;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] slot;
    logic       clr;
    logic       exp_ready;
    logic [3:0] exp_count;
    logic       exp_err;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  logic [2:0] model_q[$];
  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] press_mask(input logic [2:0] c);
    logic [4:0] one;
    one = 5'd1;
    if (c == 3'd7) return 5'd0;
    return one << c;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.b    = {b5, b4, b3, b2, b1};
    o.busy = busy;
    o.done = done;
    return o;
  endfunction

  // Expected per-cycle trace of a replay starting in the cycle after start.
  task automatic build_expect(input int iters, input int abort_cycle);
    obs_t e;
    exp_q.delete();
    for (int it = 0; it < iters; it++) begin
      for (int i = 0; i < model_q.size(); i++) begin
        for (int t = 0; t < int'(TICK_DIV); t++) begin
          e.b    = press_mask(model_q[i]);
          e.busy = 1'b1;
          e.done = (it > 0) && (i == 0) && (t == 0);
          exp_q.push_back(e);
        end
        for (int t = 0; t < int'(TICK_DIV); t++) begin
          e.b    = 5'd0;
          e.busy = 1'b1;
          e.done = 1'b0;
          exp_q.push_back(e);
        end
      end
    end
    if (abort_cycle > 0) begin
      while (exp_q.size() > abort_cycle) void'(exp_q.pop_back());
      e = '{b: 5'd0, busy: 1'b0, done: 1'b0};
      exp_q.push_back(e);
      exp_q.push_back(e);
    end else begin
      e = '{b: 5'd0, busy: 1'b0, done: 1'b1};
      exp_q.push_back(e);
      e.done = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic run_replay(input string name, input int abort_cycle);
    obs_t a, e;
    int   k;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 1;
    while (exp_q.size() > 0) begin
      if (k == abort_cycle) abort = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      a = observe();
      chk($sformatf("%s_cyc%0d", name, k), 32'(a), 32'(e));
      @(posedge clk); #1 abort = 1'b0;
      k++;
    end
  endtask

  task automatic load_code(input logic [2:0] c);
    load_valid = 1'b1;
    load_slot  = c;
    @(posedge clk); #1 load_valid = 1'b0;
    if (c != 3'd5 && c != 3'd6 && model_q.size() < DEPTH) model_q.push_back(c);
  endtask

  task automatic clear_store();
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    model_q.delete();
  endtask

  task automatic apply_vec(input int i);
    load_valid = vt[i].valid;
    load_slot  = vt[i].slot;
    clr        = vt[i].clr;
    @(negedge clk);
    chk($sformatf("vec%0d_ready", i), 32'(load_ready), 32'(vt[i].exp_ready));
    @(posedge clk); #1;
    load_valid = 1'b0;
    clr        = 1'b0;
    if (vt[i].clr) model_q.delete();
    else if (vt[i].valid && vt[i].slot != 3'd5 && vt[i].slot != 3'd6 && model_q.size() < DEPTH)
      model_q.push_back(vt[i].slot);
    chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].exp_count));
    chk($sformatf("vec%0d_err", i), 32'(load_err), 32'(vt[i].exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    //        valid  slot  clr   ready  count  err
    vt[0]  = '{1'b1, 3'd0, 1'b0, 1'b1, 4'd1, 1'b0};
    vt[1]  = '{1'b1, 3'd1, 1'b0, 1'b1, 4'd2, 1'b0};
    vt[2]  = '{1'b1, 3'd5, 1'b0, 1'b1, 4'd2, 1'b1};
    vt[3]  = '{1'b0, 3'd0, 1'b0, 1'b1, 4'd2, 1'b0};
    vt[4]  = '{1'b1, 3'd6, 1'b0, 1'b1, 4'd2, 1'b1};
    vt[5]  = '{1'b1, 3'd2, 1'b0, 1'b1, 4'd3, 1'b0};
    vt[6]  = '{1'b1, 3'd3, 1'b0, 1'b1, 4'd4, 1'b0};
    vt[7]  = '{1'b1, 3'd4, 1'b0, 1'b1, 4'd5, 1'b0};
    vt[8]  = '{1'b1, 3'd7, 1'b0, 1'b1, 4'd6, 1'b0};
    vt[9]  = '{1'b1, 3'd0, 1'b0, 1'b1, 4'd7, 1'b0};
    vt[10] = '{1'b1, 3'd1, 1'b0, 1'b1, 4'd8, 1'b0};
    vt[11] = '{1'b1, 3'd2, 1'b0, 1'b0, 4'd8, 1'b0};
    vt[12] = '{1'b1, 3'd5, 1'b0, 1'b0, 4'd8, 1'b0};
    vt[13] = '{1'b1, 3'd0, 1'b1, 1'b0, 4'd0, 1'b0};
    vt[14] = '{1'b1, 3'd3, 1'b0, 1'b1, 4'd1, 1'b0};
    vt[15] = '{1'b0, 3'd0, 1'b1, 1'b0, 4'd0, 1'b0};

    rst        = 1'b0;
    load_valid = 1'b0;
    load_slot  = 3'd0;
    clr        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_b",     32'({b5, b4, b3, b2, b1}), 32'(0));
    chk("rst_busy",  32'(busy),       32'(0));
    chk("rst_done",  32'(done),       32'(0));
    chk("rst_err",   32'(load_err),   32'(0));
    chk("rst_ready", 32'(load_ready), 32'(0));
    chk("rst_count", 32'(count),      32'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Fill to full, illegal codes, offers while full
    for (int i = 0; i <= 12; i++) apply_vec(i);

`ifndef LRU_PRESS_PLAYER_LOOP_EN
    // Replay all eight stored codes; ninth offer must not appear
    build_expect(1, 0);
    run_replay("full8", 0);
`endif

    // Clear wins over load, reload, clear again
    for (int i = 13; i <= 15; i++) apply_vec(i);

`ifdef LRU_PRESS_PLAYER_LOOP_EN
    load_code(3'd3);
    build_expect(3, 3 * 2 * int'(TICK_DIV));
    run_replay("loop3", 3 * 2 * int'(TICK_DIV));
    chk("loop_count", 32'(count), 32'(model_q.size()));
`else
    // Start with an empty store
    build_expect(1, 0);
    run_replay("empty", 0);

    // Codes 0,2
    load_code(3'd0);
    load_code(3'd2);
    build_expect(1, 0);
    run_replay("seq02", 0);

    // Abort in cycle 2, then replay again
    clear_store();
    load_code(3'd4);
    build_expect(1, 2);
    run_replay("abort4", 2);
    chk("abort_count", 32'(count), 32'(1));
    build_expect(1, 0);
    run_replay("rerun4", 0);

    // Rest code then b2
    clear_store();
    load_code(3'd7);
    load_code(3'd1);
    build_expect(1, 0);
    run_replay("seq71", 0);

    // Reset asserted mid-press drops the button without a clock edge
    clear_store();
    load_code(3'd1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_pre_b", 32'({b5, b4, b3, b2, b1}), 32'(5'b00010));
    #2 rst = 1'b0;
    #1;
    chk("midrst_b",     32'({b5, b4, b3, b2, b1}), 32'(0));
    chk("midrst_busy",  32'(busy),       32'(0));
    chk("midrst_ready", 32'(load_ready), 32'(0));
    @(posedge clk); #1 rst = 1'b1;
    model_q.delete();
    @(negedge clk);
    chk("midrst_count", 32'(count), 32'(0));
    chk("midrst_idle",  32'(busy),  32'(0));
    @(posedge clk); #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
